// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : RV32I instruction fetch stage with IF/ID pipeline register.
//             Owns the PC, never speculates past control-flow instructions
//             (waits BRANCH_BUBBLES cycles or for a redirect), and exposes
//             opcode-masked rs1/rs2/rd to the hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int          XLEN           = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BRANCH_BUBBLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic [31:0]     imem_data_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out
);

  localparam int          CNT_W       = $clog2(BRANCH_BUBBLES + 1);
  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_OP     = 7'b0110011;

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_BR_WAIT = 1'b1
  } state_t;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc_id;
  logic            r_valid;
  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]      w_fetch_opc;
  logic            w_fetch_ctrl;
  logic [XLEN-1:0] w_target;
  logic [6:0]      w_id_opc;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_use_rd;

  assign w_fetch_opc  = imem_data_in[6:0];
  assign w_fetch_ctrl = (w_fetch_opc == c_OP_BRANCH) || (w_fetch_opc == c_OP_JAL) ||
                        (w_fetch_opc == c_OP_JALR);
  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign w_target     = branch_target_in & ~XLEN'(3);

  // PC, IF/ID register and no-speculation sequencer; priority rst > redirect > stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= XLEN'(RESET_PC);
      r_instr <= c_NOP;
      r_pc_id <= '0;
      r_valid <= 1'b0;
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else if (branch_taken_in) begin
      // Redirect squashes whatever is being latched this edge.
      r_pc    <= w_target;
      r_instr <= c_NOP;
      r_valid <= 1'b0;
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else if (!stall_in) begin
      case (r_state)
        S_RUN: begin
          r_instr <= imem_data_in;
          r_pc_id <= r_pc;
          r_valid <= 1'b1;
          if (w_fetch_ctrl) begin
            // Hold the PC until the branch resolves or the bubbles run out.
            r_state <= S_BR_WAIT;
            r_cnt   <= CNT_W'(BRANCH_BUBBLES);
          end else begin
            r_pc <= r_pc + XLEN'(4);
          end
        end
        S_BR_WAIT: begin
          r_instr <= c_NOP;
          r_valid <= 1'b0;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_pc    <= r_pc + XLEN'(4);
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign w_id_opc = r_instr[6:0];

  // Which register fields the ID-stage opcode actually uses.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (w_id_opc)
      c_OP_LUI:    w_use_rd  = 1'b1;
      c_OP_AUIPC:  w_use_rd  = 1'b1;
      c_OP_JAL:    w_use_rd  = 1'b1;
      c_OP_JALR:   begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      c_OP_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      c_OP_LOAD:   begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      c_OP_STORE:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      c_OP_IMM:    begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      c_OP_OP:     begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
      default:     ;
    endcase
  end

  assign imem_addr_out = r_pc;
  assign instr_out     = r_instr;
  assign pc_out        = r_pc_id;
  assign valid_out     = r_valid;
  assign rs1_out       = (r_valid && w_use_rs1) ? r_instr[19:15] : 5'd0;
  assign rs2_out       = (r_valid && w_use_rs2) ? r_instr[24:20] : 5'd0;
  assign rd_out        = (r_valid && w_use_rd)  ? r_instr[11:7]  : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed, table-driven self-checking bench for fetch_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:127];

  fetch_stage #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .BRANCH_BUBBLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .imem_addr_out    (imem_addr_out),
    .imem_data_in     (imem_data_in),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .valid_out        (valid_out),
    .rs1_out          (rs1_out),
    .rs2_out          (rs2_out),
    .rd_out           (rd_out)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory, 128 words, address bits [8:2].
  assign imem_data_in = mem[imem_addr_out[8:2]];

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stall, input logic br, input logic [31:0] tgt,
                     input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_instr,
                     input logic chk_pc, input logic [31:0] e_pc,
                     input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.chk_pc = chk_pc; v.e_pc = e_pc;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic chk_pc, input logic [31:0] e_pc,
                       input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd);
    cmp({tag, ".addr"},  imem_addr_out, e_addr);
    cmp({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e_valid});
    cmp({tag, ".instr"}, instr_out, e_instr);
    if (chk_pc) cmp({tag, ".pc"}, pc_out, e_pc);
    cmp({tag, ".rs1"}, {27'd0, rs1_out}, {27'd0, e_rs1});
    cmp({tag, ".rs2"}, {27'd0, rs2_out}, {27'd0, e_rs2});
    cmp({tag, ".rd"},  {27'd0, rd_out},  {27'd0, e_rd});
  endtask

  // Drive at negedge, then sample 1 time unit after the next posedge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall_in = s; branch_taken_in = b; branch_target_in = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = c_NOP;
    mem[0]   = 32'h0010_0093; // 0x00  addi x1,x0,1
    mem[1]   = 32'h0020_0113; // 0x04  addi x2,x0,2
    mem[2]   = 32'h0030_0193; // 0x08  addi x3,x0,3
    mem[3]   = 32'h0040_0213; // 0x0C  addi x4,x0,4
    mem[4]   = 32'h0020_8463; // 0x10  beq  x1,x2,+8
    mem[5]   = 32'h0050_0293; // 0x14  addi x5,x0,5
    mem[6]   = 32'h0060_0313; // 0x18  addi x6,x0,6
    mem[7]   = 32'h0053_2023; // 0x1C  sw   x5,0(x6)
    mem[8]   = 32'h0E00_00EF; // 0x20  jal  x1,+0xE0
    mem[64]  = 32'h0070_0393; // 0x100 addi x7,x0,7
    mem[65]  = 32'h0080_0413; // 0x104 addi x8,x0,8
    mem[66]  = 32'h0000_8067; // 0x108 jalr x0,0(x1)
    mem[127] = 32'h00A0_0513; // 0x1FC / 0xFFFFFFFC addi x10,x0,10

    //   stall br tgt           addr          v  instr          chkpc pc            rs1 rs2 rd
    add(0, 0, 32'h0,      32'h0000_0004, 1, 32'h0010_0093, 1, 32'h0000_0000, 0, 0, 1);
    add(0, 0, 32'h0,      32'h0000_0008, 1, 32'h0020_0113, 1, 32'h0000_0004, 0, 0, 2);
    add(1, 0, 32'h0,      32'h0000_0008, 1, 32'h0020_0113, 1, 32'h0000_0004, 0, 0, 2);
    add(1, 0, 32'h0,      32'h0000_0008, 1, 32'h0020_0113, 1, 32'h0000_0004, 0, 0, 2);
    add(0, 0, 32'h0,      32'h0000_000C, 1, 32'h0030_0193, 1, 32'h0000_0008, 0, 0, 3);
    add(0, 0, 32'h0,      32'h0000_0010, 1, 32'h0040_0213, 1, 32'h0000_000C, 0, 0, 4);
    add(0, 0, 32'h0,      32'h0000_0010, 1, 32'h0020_8463, 1, 32'h0000_0010, 1, 2, 0);
    add(0, 0, 32'h0,      32'h0000_0010, 0, c_NOP,         0, 32'h0,         0, 0, 0);
    add(0, 0, 32'h0,      32'h0000_0014, 0, c_NOP,         0, 32'h0,         0, 0, 0);
    add(0, 0, 32'h0,      32'h0000_0018, 1, 32'h0050_0293, 1, 32'h0000_0014, 0, 0, 5);
    add(0, 0, 32'h0,      32'h0000_001C, 1, 32'h0060_0313, 1, 32'h0000_0018, 0, 0, 6);
    add(0, 0, 32'h0,      32'h0000_0020, 1, 32'h0053_2023, 1, 32'h0000_001C, 6, 5, 0);
    add(0, 0, 32'h0,      32'h0000_0020, 1, 32'h0E00_00EF, 1, 32'h0000_0020, 0, 0, 1);
    add(0, 1, 32'h103,    32'h0000_0100, 0, c_NOP,         0, 32'h0,         0, 0, 0);
    add(0, 0, 32'h0,      32'h0000_0104, 1, 32'h0070_0393, 1, 32'h0000_0100, 0, 0, 7);
    add(0, 0, 32'h0,      32'h0000_0108, 1, 32'h0080_0413, 1, 32'h0000_0104, 0, 0, 8);
    add(0, 0, 32'h0,      32'h0000_0108, 1, 32'h0000_8067, 1, 32'h0000_0108, 1, 0, 0);
    add(0, 0, 32'h0,      32'h0000_0108, 0, c_NOP,         0, 32'h0,         0, 0, 0);

    rst = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0; branch_target_in = '0;

    // Reset state.
    step(1, 0, 0, 32'h0);
    check("reset", 32'h0, 0, c_NOP, 1, 32'h0, 0, 0, 0);

    // Table: straight line, stall, not-taken beq, taken jal, jalr into BR_WAIT.
    foreach (vecs[i]) begin
      step(0, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr,
            vecs[i].chk_pc, vecs[i].e_pc, vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_rd);
    end

    // Reset while in BR_WAIT (one bubble still outstanding).
    step(1, 0, 0, 32'h0);
    check("rst_brwait", 32'h0, 0, c_NOP, 1, 32'h0, 0, 0, 0);
    step(0, 0, 0, 32'h0);
    check("restart0", 32'h4, 1, 32'h0010_0093, 1, 32'h0, 0, 0, 1);
    step(0, 0, 0, 32'h0);
    check("restart4", 32'h8, 1, 32'h0020_0113, 1, 32'h4, 0, 0, 2);

    // Redirect to the beq, then redirect on the edge that latches it: squashed.
    step(0, 0, 1, 32'h0000_0010);
    check("redir_beq", 32'h10, 0, c_NOP, 0, 32'h0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFF);
    check("redir_same_edge", 32'hFFFF_FFFC, 0, c_NOP, 0, 32'h0, 0, 0, 0);

    // PC wraps from 0xFFFFFFFC to 0.
    step(0, 0, 0, 32'h0);
    check("wrap_top", 32'h0, 1, 32'h00A0_0513, 1, 32'hFFFF_FFFC, 0, 0, 10);
    step(0, 0, 0, 32'h0);
    check("wrap_zero", 32'h4, 1, 32'h0010_0093, 1, 32'h0, 0, 0, 1);

    // Redirect beats a simultaneous stall; a following stall holds the bubble.
    step(0, 1, 1, 32'h0000_0014);
    check("redir_over_stall", 32'h14, 0, c_NOP, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 32'h0);
    check("stall_bubble", 32'h14, 0, c_NOP, 0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 32'h0);
    check("after_stall", 32'h18, 1, 32'h0050_0293, 1, 32'h14, 0, 0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
